// File: rtl/obi_xbar_pkg.sv
// rtl/obi_xbar_pkg.sv - shared widths, id types and constants for obi_xbar
package obi_xbar_pkg;

  localparam int DEF_MASTERS = 3;
  localparam int DEF_SLAVES  = 8;

  // Width of an index that can name n distinct items, never below one bit
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int mid_w(input int masters);
    return idx_w(masters);
  endfunction

  // Slave ids include the decode-error pseudo-slave at index SLAVES
  function automatic int sid_w(input int slaves);
    return idx_w(slaves + 1);
  endfunction

  localparam int MID_W = mid_w(DEF_MASTERS);
  localparam int SID_W = sid_w(DEF_SLAVES);

  typedef logic [MID_W-1:0] mid_t;
  typedef logic [SID_W-1:0] sid_t;

  localparam logic [1023:0] ERR_RDATA = '0;

endpackage

// File: rtl/obi_xbar_rsp_fifo.sv
// rtl/obi_xbar_rsp_fifo.sv - per-slave FIFO of master ids awaiting a response
module obi_xbar_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] id_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  // Pops on an empty FIFO and pushes on a full one are dropped
  assign full_o  = (r_cnt == CW'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = r_mem[r_rd];

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= id_i;
  end

  // Pointers wrap modulo DEPTH; push and pop together leave occupancy alone
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= wrap_inc(r_wr);
      if (w_pop)  r_rd <= wrap_inc(r_rd);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/obi_xbar.sv
// rtl/obi_xbar.sv - OBI crossbar with base/mask decode, per-slave arbitration, decode-error responder (OBI_XBAR_RR_EN selects round-robin)
module obi_xbar import obi_xbar_pkg::*; #(
  parameter int MASTERS = DEF_MASTERS,
  parameter int SLAVES  = DEF_SLAVES,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [MASTERS-1:0]                  master_req_i,
  output logic [MASTERS-1:0]                  master_gnt_o,
  input  logic [MASTERS-1:0]                  master_we_i,
  input  logic [MASTERS-1:0][DATA_W/8-1:0]    master_be_i,
  input  logic [MASTERS-1:0][ADDR_W-1:0]      master_addr_i,
  input  logic [MASTERS-1:0][DATA_W-1:0]      master_wdata_i,
  output logic [MASTERS-1:0]                  master_rvalid_o,
  output logic [MASTERS-1:0][DATA_W-1:0]      master_rdata_o,
  output logic [MASTERS-1:0]                  master_err_o,
  input  logic [SLAVES-1:0][ADDR_W-1:0]       slave_addr_mask_i,
  input  logic [SLAVES-1:0][ADDR_W-1:0]       slave_addr_base_i,
  output logic [SLAVES-1:0]                   slave_req_o,
  input  logic [SLAVES-1:0]                   slave_gnt_i,
  output logic [SLAVES-1:0]                   slave_we_o,
  output logic [SLAVES-1:0][DATA_W/8-1:0]     slave_be_o,
  output logic [SLAVES-1:0][ADDR_W-1:0]       slave_addr_o,
  output logic [SLAVES-1:0][DATA_W-1:0]       slave_wdata_o,
  input  logic [SLAVES-1:0]                   slave_rvalid_i,
  input  logic [SLAVES-1:0][DATA_W-1:0]       slave_rdata_i
);

  localparam int MIDW = mid_w(MASTERS);
  localparam int SIDW = sid_w(SLAVES);
  localparam int CW   = $clog2(MAX_OUT + 1);

  logic [SIDW-1:0]               w_tgt [MASTERS];
  logic [MASTERS-1:0]            w_elig;
  logic [SLAVES-1:0]             w_req;
  logic [MIDW-1:0]               w_win [SLAVES];
  logic [SLAVES-1:0]             w_push;
  logic [SLAVES-1:0]             w_full;
  logic [SLAVES-1:0]             w_empty;
  logic [MIDW-1:0]               w_head [SLAVES];
  logic [MASTERS-1:0]            w_gnt;
  logic [MASTERS-1:0]            w_rvalid;
  logic [MASTERS-1:0]            w_err;
  logic [MASTERS-1:0]            w_dec;
  logic [MASTERS-1:0][DATA_W-1:0] w_rdata;
  logic [CW-1:0]                 r_cnt  [MASTERS];
  logic [SIDW-1:0]               r_last [MASTERS];
  logic [MASTERS-1:0]            r_err_pend;
`ifdef OBI_XBAR_RR_EN
  logic [MIDW-1:0]               r_rr [SLAVES];
`endif

  // Address decode: lowest matching slave wins, no match selects the ERR pseudo-slave
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      w_tgt[m] = SIDW'(SLAVES);
      for (int s = SLAVES - 1; s >= 0; s--) begin
        if ((master_addr_i[m] & slave_addr_mask_i[s]) == slave_addr_base_i[s]) w_tgt[m] = SIDW'(s);
      end
    end
  end

  // A master may only add outstanding work to the target it already waits on, keeping responses in order
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      w_elig[m] = master_req_i[m] &&
                  ((r_cnt[m] == '0) || ((w_tgt[m] == r_last[m]) && (r_cnt[m] < CW'(MAX_OUT))));
    end
  end

  // Per-slave arbiter; a full response FIFO withholds the request entirely
  always_comb begin
    logic            found;
    logic [MIDW-1:0] idx;
    for (int s = 0; s < SLAVES; s++) begin
      found    = 1'b0;
      w_win[s] = '0;
      for (int k = 0; k < MASTERS; k++) begin
`ifdef OBI_XBAR_RR_EN
        idx = MIDW'((int'(r_rr[s]) + k) % MASTERS);
`else
        idx = MIDW'(k);
`endif
        if (!found && w_elig[idx] && (w_tgt[idx] == SIDW'(s))) begin
          found    = 1'b1;
          w_win[s] = idx;
        end
      end
      w_req[s] = found && !w_full[s];
    end
  end

  assign w_push = w_req & slave_gnt_i;

  // Grant back to masters; the ERR target accepts any eligible master at once
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      w_gnt[m] = (w_tgt[m] == SIDW'(SLAVES)) && w_elig[m];
      for (int s = 0; s < SLAVES; s++) begin
        if ((w_tgt[m] == SIDW'(s)) && w_req[s] && (w_win[s] == MIDW'(m))) w_gnt[m] = slave_gnt_i[s];
      end
    end
  end

  for (genvar s = 0; s < SLAVES; s++) begin : g_fifo
    obi_xbar_rsp_fifo #(.DEPTH(MAX_OUT), .W(MIDW)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push[s]),
      .id_i    (w_win[s]),
      .pop_i   (slave_rvalid_i[s]),
      .head_o  (w_head[s]),
      .full_o  (w_full[s]),
      .empty_o (w_empty[s])
    );
  end

  // Response routing: FIFO head names the master; ERR answers one cycle after its grant
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      w_rvalid[m] = r_err_pend[m];
      w_err[m]    = r_err_pend[m];
      w_rdata[m]  = ERR_RDATA[DATA_W-1:0];
    end
    for (int s = 0; s < SLAVES; s++) begin
      for (int m = 0; m < MASTERS; m++) begin
        if (slave_rvalid_i[s] && !w_empty[s] && (w_head[s] == MIDW'(m))) begin
          w_rvalid[m] = 1'b1;
          w_err[m]    = 1'b0;
          w_rdata[m]  = slave_rdata_i[s];
        end
      end
    end
    for (int m = 0; m < MASTERS; m++) w_dec[m] = w_rvalid[m] && (r_cnt[m] != '0);
  end

  // Per-master outstanding count, last target and pending ERR response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_pend <= '0;
      for (int m = 0; m < MASTERS; m++) begin
        r_cnt[m]  <= '0;
        r_last[m] <= '0;
      end
    end else begin
      for (int m = 0; m < MASTERS; m++) begin
        r_err_pend[m] <= w_gnt[m] && (w_tgt[m] == SIDW'(SLAVES));
        if (w_gnt[m]) r_last[m] <= w_tgt[m];
        if (w_gnt[m] && !w_dec[m])      r_cnt[m] <= r_cnt[m] + 1'b1;
        else if (w_dec[m] && !w_gnt[m]) r_cnt[m] <= r_cnt[m] - 1'b1;
      end
    end
  end

`ifdef OBI_XBAR_RR_EN
  // Round-robin pointer moves past the winner only on a completed handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SLAVES; s++) r_rr[s] <= '0;
    end else begin
      for (int s = 0; s < SLAVES; s++) begin
        if (w_push[s]) r_rr[s] <= (w_win[s] == MIDW'(MASTERS - 1)) ? '0 : w_win[s] + 1'b1;
      end
    end
  end
`endif

  // Zero-cycle address path to slaves; idle slaves and everything under reset see zeros
  always_comb begin
    for (int s = 0; s < SLAVES; s++) begin
      slave_req_o[s]   = 1'b0;
      slave_we_o[s]    = 1'b0;
      slave_be_o[s]    = '0;
      slave_addr_o[s]  = '0;
      slave_wdata_o[s] = '0;
      if (!rst_i && w_req[s]) begin
        slave_req_o[s]   = 1'b1;
        slave_we_o[s]    = master_we_i[w_win[s]];
        slave_be_o[s]    = master_be_i[w_win[s]];
        slave_addr_o[s]  = master_addr_i[w_win[s]];
        slave_wdata_o[s] = master_wdata_i[w_win[s]];
      end
    end
  end

  assign master_gnt_o    = rst_i ? '0 : w_gnt;
  assign master_rvalid_o = rst_i ? '0 : w_rvalid;
  assign master_err_o    = rst_i ? '0 : w_err;
  assign master_rdata_o  = rst_i ? '0 : w_rdata;

endmodule
